// File: rtl/sm_adder_pkg.sv
// Shared widths and types for the sign-magnitude adder lookup path.
package sm_adder_pkg;

  localparam int OP_WIDTH   = 4;
  localparam int SUM_WIDTH  = 5;
  localparam int ADDR_WIDTH = 2 * OP_WIDTH;

  // Operand pair as it appears on the ROM address: {a, b}
  typedef struct packed {
    logic [OP_WIDTH-1:0] a;
    logic [OP_WIDTH-1:0] b;
  } op_pair_t;

  typedef logic [SUM_WIDTH-1:0] sum_t;

endpackage

// File: rtl/sm_adder_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches upward from the requester after the last grant.
module rr_arbiter #(
  parameter  int NUM_REQ  = 4,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_REQ-1:0]  eligible,
  input  logic                advance,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx
);

  logic [ID_WIDTH-1:0] last_grant;

  // First eligible requester starting at last_grant+1, wrapping modulo NUM_REQ
  always_comb begin
    logic                found;
    logic [ID_WIDTH-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(last_grant) + 1 + k) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Pointer resets to NUM_REQ-1 so requester 0 wins first; moves only on a grant
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
    end else if (advance) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/sync_rom.sv
// Synchronous sign-magnitude sum table: data_o = a + b, one cycle after addr_i.
module sync_rom
  import sm_adder_pkg::*;
(
  input  logic                  clk_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output sum_t                  data_o
);

  localparam int MAG_W = OP_WIDTH - 1;
  localparam int SUM_MAG_W = SUM_WIDTH - 1;

  // Table contents: same signs add magnitudes, differing signs subtract the smaller; zero is always +0
  function automatic sum_t sm_lookup(input op_pair_t p);
    logic [SUM_MAG_W-1:0] ma;
    logic [SUM_MAG_W-1:0] mb;
    logic [SUM_MAG_W-1:0] mag;
    logic                 sgn;
    ma = SUM_MAG_W'(p.a[MAG_W-1:0]);
    mb = SUM_MAG_W'(p.b[MAG_W-1:0]);
    if (p.a[OP_WIDTH-1] == p.b[OP_WIDTH-1]) begin
      mag = ma + mb;
      sgn = p.a[OP_WIDTH-1];
    end else if (ma >= mb) begin
      mag = ma - mb;
      sgn = p.a[OP_WIDTH-1];
    end else begin
      mag = mb - ma;
      sgn = p.b[OP_WIDTH-1];
    end
    if (mag == '0) sgn = 1'b0;
    return {sgn, mag};
  endfunction

  // Registered read
  always_ff @(posedge clk_i) begin
    data_o <= sm_lookup(op_pair_t'(addr_i));
  end

endmodule

// File: rtl/sm_adder_arbiter.sv
// Shares one synchronous sign-magnitude adder ROM among NUM_REQ requesters.
module sm_adder_arbiter
  import sm_adder_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int OP_WIDTH  = sm_adder_pkg::OP_WIDTH,
  parameter  int SUM_WIDTH = sm_adder_pkg::SUM_WIDTH,
  localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*OP_WIDTH-1:0]   req_a_i,
  input  logic [NUM_REQ*OP_WIDTH-1:0]   req_b_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [NUM_REQ*SUM_WIDTH-1:0]  rsp_sum_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  output logic [2*OP_WIDTH-1:0]         rom_addr_o,
  input  logic [SUM_WIDTH-1:0]          rom_data_i
);

  logic [NUM_REQ-1:0]  busy;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] grant_idx;
  logic                grant_vld;
  logic                vld_p1;
  logic [ID_WIDTH-1:0] id_p1;

  // A requester with a held response or a lookup in flight cannot issue again
  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      busy[i] = rsp_valid_o[i] | (vld_p1 && (id_p1 == ID_WIDTH'(i)));
    end
  end

  assign eligible    = req_valid_i & ~busy & {NUM_REQ{rst_ni}};
  assign grant_vld   = |grant;
  assign req_ready_o = grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .eligible  (eligible),
    .advance   (grant_vld),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Drive the granted operand pair onto the ROM address, zero when idle
  always_comb begin
    op_pair_t pair_g;
    pair_g   = '0;
    if (grant_vld) begin
      pair_g.a = req_a_i[grant_idx*OP_WIDTH +: OP_WIDTH];
      pair_g.b = req_b_i[grant_idx*OP_WIDTH +: OP_WIDTH];
    end
    rom_addr_o = pair_g;
  end

  // p0 -> p1: lookup issued, ROM read in progress
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p1 <= 1'b0;
      id_p1  <= '0;
    end else begin
      vld_p1 <= grant_vld;
      if (grant_vld) id_p1 <= grant_idx;
    end
  end

  // p1 -> response: capture ROM data into the tagged requester, clear on consume
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_o <= '0;
      rsp_sum_o   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (vld_p1 && (id_p1 == ID_WIDTH'(i))) begin
          rsp_sum_o[i*SUM_WIDTH +: SUM_WIDTH] <= rom_data_i;
          rsp_valid_o[i]                      <= 1'b1;
        end else if (rsp_valid_o[i] && rsp_ready_i[i]) begin
          rsp_valid_o[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sm_adder_arbiter.sv
// Self-checking bench for sm_adder_arbiter driving a real sync_rom.
module tb_sm_adder_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [5*N-1:0] rsp_sum;
  logic [N-1:0]   rsp_ready;
  logic [7:0]     rom_addr;
  logic [4:0]     rom_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         id;
    logic [4:0] sum;
    int         due;
  } exp_t;

  exp_t       sb_q[$];
  logic [N-1:0] prev_vld = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sm_adder_arbiter #(.NUM_REQ(N)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_sum_o   (rsp_sum),
    .rsp_ready_i (rsp_ready),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data)
  );

  sync_rom u_rom (
    .clk_i  (clk),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  // Reference: signed integer sum re-encoded as sign-magnitude, zero as +0
  function automatic logic [4:0] ref_sum(input logic [3:0] a, input logic [3:0] b);
    int va, vb, s;
    va = int'(a[2:0]);
    vb = int'(b[2:0]);
    if (a[3]) va = -va;
    if (b[3]) vb = -vb;
    s = va + vb;
    if (s < 0) return {1'b1, 4'(-s)};
    return {1'b0, 4'(s)};
  endfunction

  // Scoreboard: push on acceptance, pop and compare on each rising response valid
  always @(negedge clk) begin
    exp_t e;
    if (rst_n !== 1'b1) begin
      sb_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && !prev_vld[i]) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: req%0d got sum %b at cycle %0d, expected no response", i, rsp_sum[i*5 +: 5], cyc);
          end else begin
            e = sb_q.pop_front();
            if (e.id != i || e.sum !== rsp_sum[i*5 +: 5] || e.due != cyc) begin
              errors++;
              $display("FAIL sb_response: got req%0d sum %b cycle %0d, expected req%0d sum %b cycle %0d",
                       i, rsp_sum[i*5 +: 5], cyc, e.id, e.sum, e.due);
            end
          end
        end
      end
      while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        e = sb_q.pop_front();
        checks++;
        errors++;
        $display("FAIL sb_missing: req%0d sum %b due cycle %0d never arrived (now %0d)", e.id, e.sum, e.due, cyc);
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_q.push_back('{i, ref_sum(req_a[i*4 +: 4], req_b[i*4 +: 4]), cyc + 2});
        end
      end
    end
    prev_vld = rsp_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = '0;
    req_a     = '1;
    req_b     = '1;
    tick();
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || rom_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_issue: ready %b addr %h, expected 0000 00", req_ready, rom_addr);
    end
    checks++;
    if (rsp_valid !== '0 || rsp_sum !== '0) begin
      errors++;
      $display("FAIL reset_rsp: valid %b sum %h, expected 0 0", rsp_valid, rsp_sum);
    end
    tick();
    rst_n     = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_single();
    logic [5*N-1:0] exp_sum;
    exp_sum          = '0;
    exp_sum[5 +: 5]  = 5'b10010;
    req_valid = 4'b0010;
    rsp_ready = '0;
    set_op(1, 4'b0011, 4'b1101);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010 || rom_addr !== 8'h3D) begin
      errors++;
      $display("FAIL single_issue: ready %b addr %h, expected 0010 3d", req_ready, rom_addr);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== '0) begin
      errors++;
      $display("FAIL single_t1: rsp_valid %b, expected 0000", rsp_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_sum !== exp_sum) begin
      errors++;
      $display("FAIL single_t2: valid %b sum %h, expected 0010 %h", rsp_valid, rsp_sum, exp_sum);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0010) begin
      errors++;
      $display("FAIL single_hold: rsp_valid %b, expected 0010", rsp_valid);
    end
    tick();
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== '0 || rsp_sum !== exp_sum) begin
      errors++;
      $display("FAIL single_consume: valid %b sum %h, expected 0000 %h", rsp_valid, rsp_sum, exp_sum);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    do_reset();
    rsp_ready = '1;
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) set_op(i, 4'($urandom), 4'($urandom));
      exp_g = '0;
      exp_g[k % N] = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== exp_g) begin
        errors++;
        $display("FAIL rr_order step %0d: ready %b, expected %b", k, req_ready, exp_g);
      end
      tick();
    end
    req_valid = '0;
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 4'b1011;
    req_valid = 4'b0100;
    set_op(2, 4'b0011, 4'b0100);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_issue: ready %b, expected 0100", req_ready);
    end
    tick();
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      set_op(0, 4'($urandom), 4'($urandom));
      set_op(1, 4'($urandom), 4'($urandom));
      set_op(3, 4'($urandom), 4'($urandom));
      @(negedge clk);
      checks++;
      if (req_ready[2] !== 1'b0 || req_ready === '0) begin
        errors++;
        $display("FAIL bp_grant step %0d: ready %b, expected req2 low and another granted", k, req_ready);
      end
      if (k >= 1) begin
        checks++;
        if (rsp_valid[2] !== 1'b1 || rsp_sum[10 +: 5] !== 5'b00111) begin
          errors++;
          $display("FAIL bp_hold step %0d: valid2 %b sum2 %b, expected 1 00111", k, rsp_valid[2], rsp_sum[10 +: 5]);
        end
      end
      tick();
    end
    rsp_ready = '1;
    req_valid = 4'b1011;
    @(negedge clk);
    checks++;
    if (req_ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release_same: ready %b, expected req2 low", req_ready);
    end
    tick();
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (rsp_valid[2] !== 1'b0 || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release_next: valid2 %b ready %b, expected 0 0100", rsp_valid[2], req_ready);
    end
    tick();
    req_valid = '0;
    repeat (4) tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    rsp_ready = '0;
    req_valid = 4'b1000;
    set_op(3, 4'b0101, 4'b1010);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL sim_grant3: ready %b, expected 1000", req_ready);
    end
    tick();
    req_valid = 4'b0001;
    set_op(0, 4'b1111, 4'b1110);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL sim_grant0: ready %b, expected 0001", req_ready);
    end
    tick();
    req_valid = '0;
    rsp_ready = 4'b1000;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b1000 || rsp_sum[15 +: 5] !== 5'b00011) begin
      errors++;
      $display("FAIL sim_rsp3: valid %b sum3 %b, expected 1000 00011", rsp_valid, rsp_sum[15 +: 5]);
    end
    tick();
    rsp_ready = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_sum[0 +: 5] !== 5'b11101 || rsp_sum[15 +: 5] !== 5'b00011) begin
      errors++;
      $display("FAIL sim_same_edge: valid %b sum0 %b sum3 %b, expected 0001 11101 00011",
               rsp_valid, rsp_sum[0 +: 5], rsp_sum[15 +: 5]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0001) begin
      errors++;
      $display("FAIL sim_no_dup: valid %b, expected 0001", rsp_valid);
    end
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0001;
    rsp_ready = '0;
    set_op(0, 4'b0111, 4'b0111);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rmid_grant: ready %b, expected 0001", req_ready);
    end
    tick();
    rst_n     = 1'b0;
    req_valid = '1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || rom_addr !== 8'h00) begin
      errors++;
      $display("FAIL rmid_in_reset: ready %b addr %h, expected 0000 00", req_ready, rom_addr);
    end
    tick();
    rst_n     = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== '0) begin
        errors++;
        $display("FAIL rmid_dropped step %0d: rsp_valid %b, expected 0000", k, rsp_valid);
      end
      tick();
    end
    req_valid = '1;
    rsp_ready = '1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rmid_priority: ready %b, expected 0001", req_ready);
    end
    tick();
    req_valid = '0;
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    do_reset();
    rsp_ready = '1;
    req_valid = 4'b1000;
    set_op(3, 4'b1001, 4'b0001);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_first3: ready %b, expected 1000", req_ready);
    end
    tick();
    req_valid = '0;
    repeat (2) tick();
    req_valid = 4'b1001;
    set_op(0, 4'b0010, 4'b1010);
    set_op(3, 4'b0110, 4'b0101);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_to0: ready %b, expected 0001", req_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_then3: ready %b, expected 1000", req_ready);
    end
    tick();
    req_valid = '0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_wrap();
    repeat (3) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
